writeback_ctrl_pipe: RTL and testbench

Parametrised writeback controller for the pipelined BPF CPU. It carries register-write selects and enables from stage 2 to the register file through a configurable-depth delay line, with a flush that kills younger in-flight writes. It also exports a per-register pending scoreboard and a stall to stage 1 for read-after-write hazards, plus a saturating count of committed writeback cycles.

---
 rtl/writeback_ctrl_pipe.sv | 76 +++++++
 tb/tb_writeback_ctrl_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_ctrl_pipe.sv
// Register-writeback delay line with flush, per-register pending scoreboard, RAW stall and commit counter.
// Latency: DEPTH cycles from stage-2 input to sel/en; pending/stall are combinational (same cycle).
// Backpressure: none; one entry accepted per cycle, stall only tells stage 1 to hold its reads.
module writeback_ctrl_pipe #(
    parameter int NREGS = 2,
    parameter int SEL_W = 3,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [NREGS*SEL_W-1:0] sel_in,
    input  logic [NREGS-1:0]       en_in,
    input  logic                   flush,
    input  logic [NREGS-1:0]       rd_req,
    output logic [NREGS*SEL_W-1:0] sel,
    output logic [NREGS-1:0]       en,
    output logic [NREGS-1:0]       pending,
    output logic                   stall,
    output logic [CNT_W-1:0]       wb_count
);

    // Stage contents; a bubble is en == 0 and sel == 0, there is no valid bit.
    logic [NREGS*SEL_W-1:0] st_sel [DEPTH];
    logic [NREGS-1:0]       st_en  [DEPTH];

    // An entry with no enables carries nothing useful, so it is captured as a clean bubble.
    logic cap_take;
    assign cap_take = in_valid & (|en_in) & ~flush;

    // Delay line: capture into S[0], shift the rest; flush bubbles every stage except the output-bound one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                st_sel[k] <= '0;
                st_en[k]  <= '0;
            end
        end else begin
            st_sel[0] <= cap_take ? sel_in : '0;
            st_en[0]  <= cap_take ? en_in  : '0;
            for (int k = 1; k < DEPTH; k++) begin
                if (flush && (k < DEPTH - 1)) begin
                    st_sel[k] <= '0;
                    st_en[k]  <= '0;
                end else begin
                    st_sel[k] <= st_sel[k-1];
                    st_en[k]  <= st_en[k-1];
                end
            end
        end
    end

    assign sel = st_sel[DEPTH-1];
    assign en  = st_en[DEPTH-1];

    // Pending writes: surviving input plus every stage, including the output stage that commits this cycle.
    always_comb begin
        pending = (in_valid && !flush) ? en_in : '0;
        for (int k = 0; k < DEPTH; k++) begin
            pending = pending | st_en[k];
        end
    end

    assign stall = |(rd_req & pending);

    // Count committing cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count <= '0;
        end else if ((|st_en[DEPTH-1]) && (wb_count != {CNT_W{1'b1}})) begin
            wb_count <= wb_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_ctrl_pipe.sv
// Scoreboard bench for writeback_ctrl_pipe at DEPTH 1, 2 and 3 driven with shared stimulus.
// Latency: expectations are pushed per cycle by the stimulus and popped on the falling edge.
// Backpressure: none; the model tracks in-flight writes by age rather than by stage registers.
module tb_writeback_ctrl_pipe;
    localparam int NI = 3;
    localparam int CW = 4;

    logic       clk = 1'b1;
    logic       rst;
    logic       in_valid;
    logic [5:0] sel_in;
    logic [1:0] en_in;
    logic       flush;
    logic [1:0] rd_req;

    logic [5:0]    sel_o   [NI];
    logic [1:0]    en_o    [NI];
    logic [1:0]    pend_o  [NI];
    logic          stall_o [NI];
    logic [CW-1:0] wb_o    [NI];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] sel;
        logic [1:0] en;
        int         age;
    } ent_t;

    typedef struct {
        logic [1:0]    pend;
        logic          stall;
        logic [1:0]    en;
        logic [5:0]    sel;
        logic [CW-1:0] wb;
    } exp_t;

    ent_t fl  [NI][$];
    int   cnt [NI];
    exp_t eq  [NI][$];

    always #5 clk = ~clk;

    writeback_ctrl_pipe #(.NREGS(2), .SEL_W(3), .DEPTH(1), .CNT_W(CW)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sel_in(sel_in), .en_in(en_in),
        .flush(flush), .rd_req(rd_req), .sel(sel_o[0]), .en(en_o[0]),
        .pending(pend_o[0]), .stall(stall_o[0]), .wb_count(wb_o[0]));

    writeback_ctrl_pipe #(.NREGS(2), .SEL_W(3), .DEPTH(2), .CNT_W(CW)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sel_in(sel_in), .en_in(en_in),
        .flush(flush), .rd_req(rd_req), .sel(sel_o[1]), .en(en_o[1]),
        .pending(pend_o[1]), .stall(stall_o[1]), .wb_count(wb_o[1]));

    writeback_ctrl_pipe #(.NREGS(2), .SEL_W(3), .DEPTH(3), .CNT_W(CW)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sel_in(sel_in), .en_in(en_in),
        .flush(flush), .rd_req(rd_req), .sel(sel_o[2]), .en(en_o[2]),
        .pending(pend_o[2]), .stall(stall_o[2]), .wb_count(wb_o[2]));

    function automatic int dep(input int m);
        return m + 1;
    endfunction

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s depth=%0d got=%0h expected=%0h t=%0t", name, dep(m), act, req, $time);
        end
    endtask

    // Expected view of the current cycle: a write is pending from input until it leaves the output.
    task automatic push_exp();
        for (int m = 0; m < NI; m++) begin
            exp_t x;
            x.en   = '0;
            x.sel  = '0;
            x.pend = (in_valid && !flush) ? en_in : 2'b00;
            for (int j = 0; j < fl[m].size(); j++) begin
                x.pend = x.pend | fl[m][j].en;
                if (fl[m][j].age == dep(m) - 1) begin
                    x.en  = fl[m][j].en;
                    x.sel = fl[m][j].sel;
                end
            end
            x.stall = |(rd_req & x.pend);
            x.wb    = CW'(cnt[m]);
            eq[m].push_back(x);
        end
    endtask

    // One clock edge of the model: the oldest write commits, a flush kills everything that
    // would not reach the output on this edge, survivors age, and a live input joins.
    task automatic advance();
        for (int m = 0; m < NI; m++) begin
            ent_t nq[$];
            ent_t e;
            for (int j = 0; j < fl[m].size(); j++) begin
                e = fl[m][j];
                if (e.age == dep(m) - 1) begin
                    if (cnt[m] < (1 << CW) - 1) cnt[m]++;
                end else if (!(flush && e.age <= dep(m) - 3)) begin
                    e.age++;
                    nq.push_back(e);
                end
            end
            if (in_valid && en_in != 2'b00 && !flush) begin
                e.sel = sel_in;
                e.en  = en_in;
                e.age = 0;
                nq.push_back(e);
            end
            fl[m] = nq;
        end
    endtask

    task automatic drive(input logic iv, input logic [5:0] s, input logic [1:0] e,
                         input logic f, input logic [1:0] rr);
        #1;
        in_valid = iv;
        sel_in   = s;
        en_in    = e;
        flush    = f;
        rd_req   = rr;
        push_exp();
        @(posedge clk);
        advance();
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 2'b00, 1'b0, 2'b00);
    endtask

    // Asynchronous reset asserted mid-cycle; the falling-edge check sees it before any clock edge.
    task automatic do_reset();
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        sel_in   = '0;
        en_in    = '0;
        flush    = 1'b0;
        rd_req   = '0;
        for (int m = 0; m < NI; m++) begin
            fl[m].delete();
            cnt[m] = 0;
        end
        push_exp();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: every falling edge, pop the expectation for this cycle and compare all outputs.
    always @(negedge clk) begin
        for (int m = 0; m < NI; m++) begin
            if (eq[m].size() > 0) begin
                exp_t x;
                x = eq[m].pop_front();
                chk("en",       m, 32'(en_o[m]),    32'(x.en));
                chk("sel",      m, 32'(sel_o[m]),   32'(x.sel));
                chk("pending",  m, 32'(pend_o[m]),  32'(x.pend));
                chk("stall",    m, 32'(stall_o[m]), 32'(x.stall));
                chk("wb_count", m, 32'(wb_o[m]),    32'(x.wb));
            end
        end
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        sel_in   = '0;
        en_in    = '0;
        flush    = 1'b0;
        rd_req   = '0;
        for (int m = 0; m < NI; m++) cnt[m] = 0;

        // Reset state with idle inputs.
        idle();
        idle();
        #1 rst = 1'b1;
        idle();

        // Single write to A, observed through each depth.
        drive(1'b1, 6'b000_101, 2'b01, 1'b0, 2'b00);
        repeat (4) idle();

        // Write X with reads of X, then an unrelated read of A inside the window.
        drive(1'b1, 6'b011_000, 2'b10, 1'b0, 2'b10);
        repeat (3) drive(1'b0, 6'd0, 2'b00, 1'b0, 2'b10);
        drive(1'b1, 6'b010_000, 2'b10, 1'b0, 2'b01);
        drive(1'b0, 6'd0, 2'b00, 1'b0, 2'b01);
        repeat (3) idle();

        // Three back-to-back entries, flush arrives with the third.
        drive(1'b1, 6'b000_011, 2'b01, 1'b0, 2'b00);
        drive(1'b1, 6'b110_000, 2'b10, 1'b0, 2'b00);
        drive(1'b1, 6'b111_111, 2'b11, 1'b1, 2'b11);
        repeat (4) idle();

        // Flush together with a full write, plus a write with no enables.
        drive(1'b1, 6'b111_111, 2'b11, 1'b1, 2'b11);
        drive(1'b1, 6'b101_101, 2'b00, 1'b0, 2'b11);
        idle();

        // Reset while both enables are being output.
        drive(1'b1, 6'b010_001, 2'b11, 1'b0, 2'b00);
        drive(1'b1, 6'b001_010, 2'b11, 1'b0, 2'b00);
        drive(1'b1, 6'b100_100, 2'b11, 1'b0, 2'b00);
        do_reset();
        repeat (2) idle();

        // Counter saturation: twenty committed writes on a 4-bit counter.
        repeat (20) drive(1'b1, 6'($urandom), {1'($urandom), 1'b1}, 1'b0, 2'($urandom));
        repeat (4) idle();
        #1;
        for (int m = 0; m < NI; m++) chk("saturated", m, 32'(wb_o[m]), 32'd15);

        // Random traffic with an extra reset in the middle.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            drive(($urandom % 4) != 0, 6'($urandom), 2'($urandom),
                  ($urandom % 8) == 0, 2'($urandom));
        end
        repeat (4) idle();

        for (int m = 0; m < NI; m++) chk("drained", m, 32'(eq[m].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
